// File: rtl/shift_operand_stage_pkg.sv
// Shared constants and types for the operand stage that feeds the combinational shifter.
package shift_pkg;
  localparam int DATA_W  = 16;
  localparam int AMT_W   = 12;
  localparam int ENTRY_W = DATA_W + AMT_W;

  localparam logic [3:0] OP_SLLI = 4'hA;
  localparam logic [3:0] OP_SLL  = 4'hB;

  localparam int OPC_HI = 15;
  localparam int OPC_LO = 12;
  localparam int IMM_HI = 3;
  localparam int IMM_LO = 0;

  typedef struct packed {
    logic [DATA_W-1:0] operand;
    logic [AMT_W-1:0]  amt;
  } shift_entry_t;
endpackage

// File: rtl/shift_operand_stage_if.sv
// Upstream/downstream bundle of the operand stage.
// Handshake: a word transfers on a rising edge where valid && ready; ready never depends on valid.
interface shift_operand_stage_if;
  import shift_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [15:0]       in_instr;
  logic [DATA_W-1:0] in_rs_data;
  logic [15:0]       in_rt_data;
  logic              fwd_valid;
  logic [DATA_W-1:0] fwd_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_to_shift;
  logic [AMT_W-1:0]  out_shift_bits;
  logic [1:0]        out_count;

  modport slave (
    input  in_valid, in_instr, in_rs_data, in_rt_data, fwd_valid, fwd_data, out_ready,
    output in_ready, out_valid, out_to_shift, out_shift_bits, out_count
  );

  modport master (
    output in_valid, in_instr, in_rs_data, in_rt_data, fwd_valid, fwd_data, out_ready,
    input  in_ready, out_valid, out_to_shift, out_shift_bits, out_count
  );
endinterface

// File: rtl/shift_operand_stage_skid_buffer2.sv
// Generic 2-entry in-order FIFO with registered ready; head and tail are separate flops
// so the head drives the outputs straight from a register.
module skid_buffer2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   count
);
  logic [1:0]   r_count;
  logic         r_in_ready;
  logic         r_out_valid;
  logic [W-1:0] r_head;
  logic [W-1:0] r_tail;

  logic       w_accept;
  logic       w_consume;
  logic [1:0] w_count_nxt;

  assign w_accept  = in_valid && r_in_ready;
  assign w_consume = r_out_valid && out_ready;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_accept, w_consume})
      2'b10:   w_count_nxt = r_count + 2'd1;
      2'b01:   w_count_nxt = r_count - 2'd1;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count     <= 2'd0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_head      <= '0;
      r_tail      <= '0;
    end else if (flush) begin
      r_count     <= 2'd0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_count     <= w_count_nxt;
      r_in_ready  <= (w_count_nxt != 2'd2);
      r_out_valid <= (w_count_nxt != 2'd0);
      if (w_accept && !w_consume) begin
        if (r_count == 2'd0) r_head <= in_data;
        else                 r_tail <= in_data;
      end else if (!w_accept && w_consume) begin
        // Draining the last entry leaves the head untouched so outputs hold.
        if (r_count == 2'd2) r_head <= r_tail;
      end else if (w_accept && w_consume) begin
        if (r_count == 2'd1) begin
          r_head <= in_data;
        end else begin
          r_head <= r_tail;
          r_tail <= in_data;
        end
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_head;
  assign count     = r_count;
endmodule

// File: rtl/shift_operand_stage.sv
// Forms operand (with forwarding) and shift amount from a decoded shift instruction
// and queues them in a skid buffer whose head feeds the shifter.
module shift_operand_stage
  import shift_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  shift_operand_stage_if.slave bus
);
  logic [3:0]        w_opcode;
  logic [3:0]        w_imm;
  logic [DATA_W-1:0] w_operand;
  logic [AMT_W-1:0]  w_amt;
  shift_entry_t      w_in_entry;
  shift_entry_t      w_out_entry;
  logic [ENTRY_W-1:0] w_out_bits;

  assign w_opcode  = bus.in_instr[OPC_HI:OPC_LO];
  assign w_imm     = bus.in_instr[IMM_HI:IMM_LO];
  assign w_operand = bus.fwd_valid ? bus.fwd_data : bus.in_rs_data;

  // Register amounts are passed unsaturated; the shifter yields 0 for amounts >= 16.
  always_comb begin
    w_amt = '0;
    case (w_opcode)
      OP_SLLI: w_amt = {8'b0, w_imm};
      OP_SLL:  w_amt = bus.in_rt_data[AMT_W-1:0];
      default: w_amt = '0;
    endcase
  end

  assign w_in_entry = '{operand: w_operand, amt: w_amt};

  skid_buffer2 #(.W(ENTRY_W)) u_buf (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (w_in_entry),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (w_out_bits),
    .count     (bus.out_count)
  );

  assign w_out_entry        = w_out_bits;
  assign bus.out_to_shift   = w_out_entry.operand;
  assign bus.out_shift_bits = w_out_entry.amt;
endmodule

// File: doc/shift_operand_stage.md
# shift_operand_stage

Registered operand stage that sits directly upstream of the combinational `shift` unit in the datapath. It accepts decoded 16-bit shift instructions over a valid/ready handshake and applies forwarding. It also forms the 16-bit operand and 12-bit shift amount, holding them in a 2-entry skid buffer whose head drives `shift.to_shift` / `shift.shift_bits` directly. It isolates the shifter from decode stalls and supports pipeline flush.

## Interface
- `DATA_W`, 16, operand width; matches `shift.to_shift`
- `AMT_W`, 12, shift-amount width; matches `shift.shift_bits`
- `clk`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high
- `flush`  in  1  discard all buffered entries
- `in_valid`  in  1  upstream word present
- `in_ready`  out  1  stage can accept; registered
- `in_instr`  in  16  instruction: [15:12] opcode, [3:0] immediate
- `in_rs_data`  in  16  register-file value of shifted operand
- `in_rt_data`  in  16  register-file value of shift-amount register
- `fwd_valid`  in  1  forwarded value overrides `in_rs_data`
- `fwd_data`  in  16  forwarded operand
- `out_valid`  out  1  head entry valid
- `out_ready`  in  1  downstream consumes head
- `out_to_shift`  out  16  to `shift.to_shift`
- `out_shift_bits`  out  12  to `shift.shift_bits`
- `out_count`  out  2  buffer occupancy, 0..2

## Operation
- Accept: `in_valid && in_ready`. Consume: `out_valid && out_ready`.
- Operand on accept: `fwd_valid ? fwd_data : in_rs_data`. Sampled only in the accept cycle.
- Shift amount on accept, selected by opcode:
  - `OP_SLLI` (4'hA): `{8'b0, in_instr[3:0]}`.
  - `OP_SLL` (4'hB): `in_rt_data[11:0]`, passed unsaturated. Amounts ≥16 reach the shifter unchanged and yield 0.
  - Any other opcode: 12'd0, so the shifter passes the operand through unchanged.
- Buffer: 2-entry FIFO, strict in-order. The head entry drives `out_*`.
- `in_ready` = occupancy < 2 as of the end of the previous cycle (registered). This is a skid buffer: an accept is never refused when occupancy was 1 and a consume happens in the same cycle.
- Simultaneous accept and consume:
  - Occupancy is unchanged.
  - The head advances, and the new word enters behind it. If the buffer was at occupancy 1, the new word becomes the head.
- Flush:
  - Occupancy becomes 0 next cycle, `out_valid`=0 and `in_ready`=1.
  - A word offered in the flush cycle is dropped even if `in_valid && in_ready`.
  - Flush has priority over accept and consume.
- `out_to_shift` / `out_shift_bits` hold their last values when `out_valid`=0. Downstream must ignore them.
- Reset values:
  - `out_valid`=0, `in_ready`=1, `out_count`=0.
  - `out_to_shift`=16'h0000, `out_shift_bits`=12'h000.
  - Both entries cleared.
- Reset asserted mid-operation discards all entries next edge, identically to flush. Reset has priority over flush.

## Timing
- Latency: a word accepted at edge N (empty buffer) is presented on `out_*` with `out_valid`=1 after edge N, i.e. 1 cycle.
- Throughput: 1 word/cycle sustained while `out_ready`=1.
- `out_ready` low:
  - Up to 2 words accumulate.
  - `in_ready` falls the cycle after occupancy reaches 2.
  - `in_ready` rises the cycle after the first consume.
- No combinational path from `out_ready` or `in_valid` to `in_ready`. `out_*` are flop outputs.
- `shift` is combinational, so `shifted` is valid in the same cycle as `out_valid`.

## Structure
- Shared package/header `shift_pkg`:
  - `DATA_W`, `AMT_W`.
  - Opcode constants `OP_SLLI`, `OP_SLL`.
  - Field positions `OPC_HI`/`OPC_LO`, `IMM_HI`/`IMM_LO`.
- Sub-module `skid_buffer2`: generic 2-entry registered-ready FIFO (width = DATA_W+AMT_W). Ports: `clk`, `reset`, `flush`, valid/ready both sides, `count`.
- `shift_operand_stage` holds only operand/amount formation plus one `skid_buffer2` instance.

## Test plan
- Reset, then `in_valid`=1 with `OP_SLLI`, imm=4'h3, `in_rs_data`=16'h0001, `out_ready`=1:
  - next cycle `out_valid`=1, `out_to_shift`=16'h0001, `out_shift_bits`=12'h003;
  - `shift.shifted`=16'h0008.
- `OP_SLL`, `in_rt_data`=16'hF014, `fwd_valid`=1, `fwd_data`=16'h00FF:
  - `out_to_shift`=16'h00FF, `out_shift_bits`=12'h014;
  - `shifted`=16'h0000.
- Opcode 4'h1, `in_rs_data`=16'hBEEF: `out_shift_bits`=0, `shifted`=16'hBEEF.
- `out_ready`=0, offer 3 words A, B, C back-to-back:
  - A and B accepted, `out_count`=2, `in_ready`=0, C held by upstream;
  - raise `out_ready`: A, B, C emerge in order, no gaps after the first.
- Occupancy 2 with `flush`=1 and a simultaneous valid offer:
  - next cycle `out_valid`=0, `out_count`=0, `in_ready`=1;
  - the offered word never appears.
- Occupancy 1 with `reset`=1 and `flush`=0: all outputs return to reset values next edge; a subsequent word has 1-cycle latency.
